// File: rtl/memory_burst_reader.sv
// Read-side burst controller for the 4 x 8-bit byte memory. It walks 1-4 addresses
// with wrap-around, waits for the read data to settle, and streams each byte out on valid/ready.
module memory_burst_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SETTLE_ST, PRESENT, DONE_ST} state_t;

  // The settle counter is 3 bits so that it can hold the largest legal SETTLE of 7.
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [2:0]        settle_cnt;

  assign mem_store = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_addr   <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr   <= start_addr;
            remaining  <= len_m1;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= SETTLE_ST;
          end
        end
        SETTLE_ST: begin
          if (settle_cnt == SETTLE_LAST) begin
            out_data  <= mem_data;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        PRESENT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (remaining != '0) begin
              // The address advances modulo the depth, so 3 wraps to 0.
              mem_addr   <= mem_addr + ADDR_W'(1);
              remaining  <= remaining - ADDR_W'(1);
              settle_cnt <= '0;
              state      <= SETTLE_ST;
            end else begin
              done  <= 1'b1;
              state <= DONE_ST;
            end
          end
        end
        DONE_ST: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_burst_reader.sv
// Directed bench for memory_burst_reader: a default-SETTLE instance and a SETTLE=3 instance,
// both reading a modelled 4-byte memory preloaded with 0x11, 0x22, 0x33, 0x44.
module tb_memory_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, out_ready;
  logic [1:0] start_addr, len_m1, mem_addr;
  logic       mem_store, out_valid, busy, done;
  logic [7:0] mem_data, out_data;

  logic       start3, out_ready3;
  logic [1:0] start_addr3, len_m13, mem_addr3;
  logic       mem_store3, out_valid3, busy3, done3;
  logic [7:0] mem_data3, out_data3;

  logic [7:0] mem [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_data  = mem[mem_addr];
  assign mem_data3 = mem[mem_addr3];

  memory_burst_reader #(.DATA_W(8), .ADDR_W(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len_m1(len_m1),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  memory_burst_reader #(.DATA_W(8), .ADDR_W(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .start_addr(start_addr3), .len_m1(len_m13),
    .mem_addr(mem_addr3), .mem_store(mem_store3), .mem_data(mem_data3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] wrap_data [4];
    logic [1:0] wrap_addr [4];
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    wrap_data[0] = 8'h33; wrap_data[1] = 8'h44; wrap_data[2] = 8'h11; wrap_data[3] = 8'h22;
    wrap_addr[0] = 2'd2;  wrap_addr[1] = 2'd3;  wrap_addr[2] = 2'd0;  wrap_addr[3] = 2'd1;

    rst_n = 1'b0; start = 1'b0; start_addr = '0; len_m1 = '0; out_ready = 1'b0;
    start3 = 1'b0; start_addr3 = '0; len_m13 = '0; out_ready3 = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_store", 32'(mem_store), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mem_store", 32'(mem_store), 32'd0);

    // Single byte from address 1
    start = 1'b1; start_addr = 2'd1; len_m1 = 2'd0; out_ready = 1'b1;
    tick(); start = 1'b0; start_addr = 2'd0;
    chk("single_t1_busy", 32'(busy), 32'd1);
    chk("single_t1_valid", 32'(out_valid), 32'd0);
    chk("single_t1_addr", 32'(mem_addr), 32'd1);
    tick();
    chk("single_t2_valid", 32'(out_valid), 32'd1);
    chk("single_t2_data", 32'(out_data), 32'h22);
    tick();
    chk("single_t3_valid", 32'(out_valid), 32'd0);
    chk("single_t3_done", 32'(done), 32'd1);
    chk("single_t3_busy", 32'(busy), 32'd1);
    tick();
    chk("single_t4_done", 32'(done), 32'd0);
    chk("single_t4_busy", 32'(busy), 32'd0);
    chk("single_t4_addr_hold", 32'(mem_addr), 32'd1);

    // Wrap burst 2,3,0,1 with a stray start (addr 3) pulsed while busy
    start = 1'b1; start_addr = 2'd2; len_m1 = 2'd3; out_ready = 1'b1;
    tick();
    start_addr = 2'd3; len_m1 = 2'd0; // start still high: must be ignored
    chk("wrap_t1_busy", 32'(busy), 32'd1);
    chk("wrap_t1_addr", 32'(mem_addr), 32'd2);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k == 4) start = 1'b0;
      if (k <= 8 && (k % 2) == 0) begin
        chk($sformatf("wrap_t%0d_valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("wrap_t%0d_data", k), 32'(out_data), 32'(wrap_data[k/2-1]));
        chk($sformatf("wrap_t%0d_addr", k), 32'(mem_addr), 32'(wrap_addr[k/2-1]));
      end else begin
        chk($sformatf("wrap_t%0d_valid", k), 32'(out_valid), 32'd0);
      end
      chk($sformatf("wrap_t%0d_done", k), 32'(done), (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("wrap_t%0d_busy", k), 32'(busy), (k == 10) ? 32'd0 : 32'd1);
      chk($sformatf("wrap_t%0d_store", k), 32'(mem_store), 32'd0);
    end

    // Backpressure: two bytes from 0, ready low for 5 cycles after first valid
    start = 1'b1; start_addr = 2'd0; len_m1 = 2'd1; out_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'h11);
      chk($sformatf("bp_hold%0d_addr", i), 32'(mem_addr), 32'd0);
      tick();
    end
    chk("bp_t7_valid", 32'(out_valid), 32'd1);
    chk("bp_t7_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_t8_valid", 32'(out_valid), 32'd0);
    chk("bp_t8_addr", 32'(mem_addr), 32'd1);
    tick();
    chk("bp_t9_valid", 32'(out_valid), 32'd1);
    chk("bp_t9_data", 32'(out_data), 32'h22);
    tick();
    chk("bp_t10_done", 32'(done), 32'd1);
    tick();
    chk("bp_t11_busy", 32'(busy), 32'd0);

    // Reset while presenting 0x44
    start = 1'b1; start_addr = 2'd3; len_m1 = 2'd1; out_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    chk("mid_data_before", 32'(out_data), 32'h44);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("mid_after_done", 32'(done), 32'd0);
    chk("mid_after_valid", 32'(out_valid), 32'd0);
    start = 1'b1; start_addr = 2'd0; len_m1 = 2'd0;
    tick(); start = 1'b0;
    tick();
    chk("mid_new_valid", 32'(out_valid), 32'd1);
    chk("mid_new_data", 32'(out_data), 32'h11);
    tick();
    chk("mid_new_done", 32'(done), 32'd1);
    tick();
    chk("mid_new_busy", 32'(busy), 32'd0);

    // SETTLE=3 instance: single byte from address 3
    start3 = 1'b1; start_addr3 = 2'd3; len_m13 = 2'd0; out_ready3 = 1'b1;
    tick(); start3 = 1'b0; start_addr3 = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("s3_t%0d_addr", k), 32'(mem_addr3), 32'd3);
      chk($sformatf("s3_t%0d_valid", k), 32'(out_valid3), 32'd0);
      tick();
    end
    chk("s3_t4_valid", 32'(out_valid3), 32'd1);
    chk("s3_t4_data", 32'(out_data3), 32'h44);
    tick();
    chk("s3_t5_valid", 32'(out_valid3), 32'd0);
    chk("s3_t5_done", 32'(done3), 32'd1);
    tick();
    chk("s3_t6_busy", 32'(busy3), 32'd0);
    chk("s3_store", 32'(mem_store3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_burst_reader.md
Name: memory_burst_reader

Overview:
- Read-side controller for the 4 x 8-bit byte memory array (addr/store/data in, muxed memory out).
- On a start request it walks a burst of 1-4 consecutive addresses, with wrap-around from 3 to 0.
- After each address it waits a settle interval, captures the muxed read byte, and presents it on a valid/ready output stream for downstream logic (LED sequencer, serial transmitter).
- It never writes; mem_store is held low at all times.

Parameters:
- DATA_W, 8, width of a memory word and of out_data.
- ADDR_W, 2, memory address width; depth = 2**ADDR_W = 4.
- SETTLE, 1, cycles mem_addr is held before mem_data is sampled (legal range 1-7).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  burst request; sampled only in IDLE.
- start_addr  in  ADDR_W  first address of the burst; captured with start.
- len_m1  in  ADDR_W  burst length minus one (0 -> 1 byte, 3 -> 4 bytes); captured with start.
- mem_addr  out  ADDR_W  address driven to the memory array's addr input.
- mem_store  out  1  store strobe to the memory array; constant 0.
- mem_data  in  DATA_W  muxed memory output from the array.
- out_data  out  DATA_W  captured byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, mem_addr=0, out_data=0, out_valid=0, busy=0, done=0, internal counters=0.
  - Reset takes effect at that edge regardless of state, including mid-burst. No further output is produced for an aborted burst.
- States: IDLE, SETTLE_ST, PRESENT, DONE_ST.
- IDLE:
  - On start=1 at edge T: latch start_addr into mem_addr, latch len_m1 into remaining, clear settle counter, go to SETTLE_ST.
  - busy=1 from T+1.
- SETTLE_ST:
  - Hold mem_addr for exactly SETTLE cycles.
  - At the edge ending the last settle cycle: out_data<=mem_data, out_valid<=1, go to PRESENT.
  - First out_valid rises at T+1+SETTLE (T+2 with default).
- PRESENT:
  - out_data and out_valid stay stable until out_valid and out_ready are both 1 at an edge (the transfer).
  - On transfer with remaining>0: out_valid<=0, mem_addr<=mem_addr+1 modulo 4 (3 wraps to 0), remaining<=remaining-1, go to SETTLE_ST.
  - On transfer with remaining=0: out_valid<=0, go to DONE_ST.
  - out_ready while out_valid=0 has no effect.
- DONE_ST:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE.
  - busy=0 and done=0 from the following cycle.
- Throughput: with out_ready held high, one byte per SETTLE+1 cycles.
  - Default 4-byte burst: valid cycles T+2, T+4, T+6, T+8; done at T+9; busy low at T+10.
- start is ignored outside IDLE; no queuing. start_addr and len_m1 are don't-care except at the accepting edge.
- mem_addr retains its last value in IDLE and DONE_ST.
- mem_store is tied to 0 in every state, including reset.
- SETTLE counter is wide enough for 7; no arithmetic overflow is possible.

Test Plan:
- Memory preloaded 0x11, 0x22, 0x33, 0x44 at addr 0-3 for all tests.
- Reset then idle: rst_n=0 for 2 cycles, then release -> mem_addr=0, out_valid=0, busy=0, done=0, mem_store=0 throughout.
- Single byte: start=1, start_addr=1, len_m1=0, out_ready=1 -> out_valid high at T+2 only with out_data=0x22; done pulse at T+3; busy low at T+4.
- Wrap burst: start_addr=2, len_m1=3, out_ready=1 -> bytes 0x33, 0x44, 0x11, 0x22 at T+2, T+4, T+6, T+8; mem_addr sequence 2, 3, 0, 1; one done pulse at T+9.
- Backpressure: burst from addr 0, len_m1=1, out_ready low for 5 cycles after first valid -> out_data holds 0x11 stable, no address advance; after ready, second byte 0x22 follows SETTLE+1 cycles after the transfer.
- Start while busy: second start with start_addr=3 pulsed during the wrap burst -> ignored; output sequence unchanged; exactly one done.
- Reset mid-burst: rst_n=0 while PRESENT with 0x44 valid -> next cycle out_valid=0, busy=0, mem_addr=0; no done pulse; a new burst then works normally.
- SETTLE=3 build: single byte from addr 3 -> out_valid at T+4 with 0x44; mem_addr stable for the 3 preceding cycles.
